// File: rtl/mips_pkg.sv
// Shared definitions for the mips_core end-of-run state dump path.
package mips_pkg;

    localparam int DEFAULT_DATA_W = 32;

    localparam logic TAG_REG = 1'b0;
    localparam logic TAG_MEM = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REG_RD,
        REG_SEND,
        MEM_REQ,
        MEM_WAIT,
        MEM_SEND,
        DONE
    } dump_state_e;

endpackage

// File: rtl/mips_state_dump_out_reg.sv
// Output holding register for the dump stream: one beat buffer with valid/ready
// handshake plus a running checksum over every accepted word.
module dump_out_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_tag,
    input  logic [15:0]       load_index,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              fire,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_tag,
    output logic [15:0]       out_index,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum
);

    function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] word);
        return acc + word;
    endfunction

    assign fire = out_valid & out_ready;

    // A load only happens while the buffer is empty, so load and fire never coincide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= TAG_REG;
            out_index <= '0;
            out_last  <= 1'b0;
            checksum  <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_tag   <= load_tag;
                out_index <= load_index;
                out_last  <= load_last;
            end else if (fire) begin
                out_valid <= 1'b0;
            end

            if (clear) begin
                checksum <= '0;
            end else if (fire) begin
                checksum <= csum_add(checksum, out_data);
            end
        end
    end

endmodule

// File: rtl/mips_state_dump.sv
// End-of-run state extractor: walks the register file then data memory and
// streams each word with tag, index, last flag and running checksum.
module mips_state_dump
    import mips_pkg::*;
#(
    parameter int  DATA_W    = DEFAULT_DATA_W,
    parameter int  NUM_REGS  = 32,
    parameter int  MEM_WORDS = 256,
    parameter bit  SKIP_R0   = 1'b1,
    localparam int REG_AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] reg_rd_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_tag,
    output logic [15:0]       out_index,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [REG_AW-1:0] REG_FIRST  = SKIP_R0 ? REG_AW'(1) : '0;
    localparam logic [REG_AW-1:0] REG_LAST   = REG_AW'(NUM_REGS - 1);
    localparam logic [MEM_AW-1:0] MEM_LAST   = MEM_AW'(MEM_WORDS - 1);
    localparam bit                REGS_EMPTY = (NUM_REGS == 1) && SKIP_R0;

    dump_state_e       state_q, state_d;
    logic [REG_AW-1:0] reg_idx_q, reg_idx_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

    logic              clear;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              load_tag;
    logic [15:0]       load_index;
    logic              load_last;
    logic              fire;

    assign reg_rd_addr = reg_idx_q;
    assign mem_rd_addr = mem_addr_q;
    assign mem_rd_en   = (state_q == MEM_REQ);
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            reg_idx_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        mem_addr_d = mem_addr_q;
        clear      = 1'b0;
        load       = 1'b0;
        load_data  = reg_rd_data;
        load_tag   = TAG_REG;
        load_index = 16'(reg_idx_q);
        load_last  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clear = 1'b1;
                    if (REGS_EMPTY) begin
                        mem_addr_d = '0;
                        state_d    = MEM_REQ;
                    end else begin
                        reg_idx_d = REG_FIRST;
                        state_d   = REG_RD;
                    end
                end
            end
            REG_RD: begin
                load    = 1'b1;
                state_d = REG_SEND;
            end
            REG_SEND: begin
                if (fire) begin
                    if (reg_idx_q == REG_LAST) begin
                        mem_addr_d = '0;
                        state_d    = MEM_REQ;
                    end else begin
                        reg_idx_d = reg_idx_q + REG_AW'(1);
                        state_d   = REG_RD;
                    end
                end
            end
            MEM_REQ: begin
                state_d = MEM_WAIT;
            end
            // Synchronous memory: data requested in MEM_REQ is present now.
            MEM_WAIT: begin
                load       = 1'b1;
                load_data  = mem_rd_data;
                load_tag   = TAG_MEM;
                load_index = 16'(mem_addr_q);
                load_last  = (mem_addr_q == MEM_LAST);
                state_d    = MEM_SEND;
            end
            MEM_SEND: begin
                if (fire) begin
                    if (mem_addr_q == MEM_LAST) begin
                        state_d = DONE;
                    end else begin
                        mem_addr_d = mem_addr_q + MEM_AW'(1);
                        state_d    = MEM_REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dump_out_reg #(
        .DATA_W(DATA_W)
    ) u_out (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .load       (load),
        .load_data  (load_data),
        .load_tag   (load_tag),
        .load_index (load_index),
        .load_last  (load_last),
        .out_ready  (out_ready),
        .fire       (fire),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_index  (out_index),
        .out_last   (out_last),
        .checksum   (checksum)
    );

endmodule

// File: tb/tb_mips_state_dump.sv
// Bench for mips_state_dump: a beat-list reference model checked every cycle,
// directed scenarios with literal expectations, then randomized dumps.
module tb_mips_state_dump;

    localparam int          DW     = 32;
    localparam int          NR     = 4;
    localparam int          MW     = 2;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    typedef struct {
        logic        tag;
        logic [15:0] idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic start0 = 1'b0;
    logic out_ready = 1'b1;
    logic ready0 = 1'b1;

    always #5 clock = ~clock;

    logic          busy, done, mem_rd_en, out_valid, out_tag, out_last;
    logic [1:0]    reg_rd_addr;
    logic [0:0]    mem_rd_addr;
    logic [DW-1:0] reg_rd_data, mem_rd_data, out_data, checksum;
    logic [15:0]   out_index;

    logic          busy0, done0, mem_rd_en0, out_valid0, out_tag0, out_last0;
    logic [1:0]    reg_rd_addr0;
    logic [0:0]    mem_rd_addr0;
    logic [DW-1:0] reg_rd_data0, mem_rd_data0, out_data0, checksum0;
    logic [15:0]   out_index0;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] mem  [MW];

    assign reg_rd_data  = regs[reg_rd_addr];
    assign reg_rd_data0 = 32'(reg_rd_addr0) * 32'd3;

    // Read data is only meaningful the cycle after a strobe; poison otherwise.
    always @(posedge clock) mem_rd_data  <= mem_rd_en  ? mem[mem_rd_addr] : POISON;
    always @(posedge clock) mem_rd_data0 <= mem_rd_en0 ? 32'(mem_rd_addr0) + 32'd100 : POISON;

    mips_state_dump #(.DATA_W(DW), .NUM_REGS(NR), .MEM_WORDS(MW), .SKIP_R0(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_index(out_index), .out_last(out_last), .checksum(checksum)
    );

    mips_state_dump #(.DATA_W(DW), .NUM_REGS(NR), .MEM_WORDS(MW), .SKIP_R0(1'b0)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .reg_rd_addr(reg_rd_addr0), .reg_rd_data(reg_rd_data0),
        .mem_rd_en(mem_rd_en0), .mem_rd_addr(mem_rd_addr0), .mem_rd_data(mem_rd_data0),
        .out_valid(out_valid0), .out_ready(ready0), .out_data(out_data0),
        .out_tag(out_tag0), .out_index(out_index0), .out_last(out_last0), .checksum(checksum0)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    beat_t       exp_q[$];
    beat_t       rec_q[$];
    beat_t       rec0_q[$];
    logic [31:0] exp_sum = '0;
    bit          active = 0;
    bit          pend_done = 0;
    bit          prev_stall = 0;
    beat_t       prev_b;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          dump_cycles = 0;
    int          done_count = 0;

    always @(negedge clock) begin
        beat_t h;
        beat_t a;
        bit    was_done;
        cyc++;
        if (reset) begin
            exp_q.delete();
            active     = 0;
            pend_done  = 0;
            prev_stall = 0;
            exp_sum    = '0;
        end else begin
            chk("busy", 64'(busy), 64'(active));
            chk("done", 64'(done), 64'(pend_done));
            chk("checksum", 64'(checksum), 64'(exp_sum));
            a.tag = out_tag; a.idx = out_index; a.data = out_data; a.last = out_last;
            if (out_valid) begin
                chk("memrd_while_valid", 64'(mem_rd_en), 64'd0);
                chk("data_known", 64'($isunknown(out_data)), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(out_valid), 64'd0);
                end else begin
                    h = exp_q[0];
                    chk("beat_tag",  64'(out_tag),   64'(h.tag));
                    chk("beat_idx",  64'(out_index), 64'(h.idx));
                    chk("beat_data", 64'(out_data),  64'(h.data));
                    chk("beat_last", 64'(out_last),  64'(h.last));
                end
            end
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data",  64'(out_data),  64'(prev_b.data));
                chk("hold_idx",   64'(out_index), 64'(prev_b.idx));
                chk("hold_tag",   64'(out_tag),   64'(prev_b.tag));
            end
            prev_stall = out_valid && !out_ready;
            prev_b     = a;
            if (done) begin
                done_count++;
                dump_cycles = cyc - accept_cyc;
            end

            was_done  = pend_done;
            pend_done = 0;
            if (out_valid && out_ready && active && exp_q.size() > 0) begin
                h = exp_q.pop_front();
                exp_sum += h.data;
                rec_q.push_back(a);
                if (h.last) begin
                    active    = 0;
                    pend_done = 1;
                end
            end else if (!active && !was_done && start) begin
                exp_q.delete();
                for (int i = 1; i < NR; i++) exp_q.push_back('{1'b0, 16'(i), regs[i], 1'b0});
                for (int j = 0; j < MW; j++) exp_q.push_back('{1'b1, 16'(j), mem[j], j == MW - 1});
                exp_sum    = '0;
                active     = 1;
                accept_cyc = cyc;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && out_valid0) rec0_q.push_back('{out_tag0, out_index0, out_data0, out_last0});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_done_reached"}, 64'(done), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_busy"},      64'(busy),        64'd0);
        chk({name, "_done"},      64'(done),        64'd0);
        chk({name, "_valid"},     64'(out_valid),   64'd0);
        chk({name, "_last"},      64'(out_last),    64'd0);
        chk({name, "_tag"},       64'(out_tag),     64'd0);
        chk({name, "_memrd"},     64'(mem_rd_en),   64'd0);
        chk({name, "_data"},      64'(out_data),    64'd0);
        chk({name, "_index"},     64'(out_index),   64'd0);
        chk({name, "_checksum"},  64'(checksum),    64'd0);
        chk({name, "_regaddr"},   64'(reg_rd_addr), 64'd0);
        chk({name, "_memaddr"},   64'(mem_rd_addr), 64'd0);
    endtask

    task automatic check_literal_beats(input string name);
        logic [31:0] ed [5] = '{32'd3, 32'd6, 32'd9, 32'd100, 32'd101};
        logic [15:0] ei [5] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
        logic        et [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        chk({name, "_beats"}, 64'(rec_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < rec_q.size(); i++) begin
            chk({name, "_lit_data"}, 64'(rec_q[i].data), 64'(ed[i]));
            chk({name, "_lit_idx"},  64'(rec_q[i].idx),  64'(ei[i]));
            chk({name, "_lit_tag"},  64'(rec_q[i].tag),  64'(et[i]));
            chk({name, "_lit_last"}, 64'(rec_q[i].last), 64'(i == 4));
        end
        chk({name, "_checksum"}, 64'(checksum), 64'd219);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        bit stalled;
        for (int i = 0; i < NR; i++) regs[i] = 32'(i * 3);
        for (int j = 0; j < MW; j++) mem[j] = 32'(j + 100);

        #1 reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset_init");
        reset = 1'b0;
        tick();

        // Directed dump, ready held high
        rec_q.delete();
        done_count = 0;
        pulse_start();
        wait_done(100, "basic");
        tick();
        check_literal_beats("basic");
        chk("basic_done_pulses", 64'(done_count), 64'd1);
        chk("basic_cycles", 64'(dump_cycles), 64'd13);

        // SKIP_R0 = 0 instance: extra register-0 beat
        rec0_q.delete();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 100) begin
            tick();
            n++;
        end
        chk("skip0_done_reached", 64'(done0), 64'd1);
        chk("skip0_beats", 64'(rec0_q.size()), 64'd6);
        if (rec0_q.size() == 6) begin
            chk("skip0_first_idx",  64'(rec0_q[0].idx),  64'd0);
            chk("skip0_first_data", 64'(rec0_q[0].data), 64'd0);
            chk("skip0_first_tag",  64'(rec0_q[0].tag),  64'd0);
            chk("skip0_last_flag",  64'(rec0_q[5].last), 64'd1);
            chk("skip0_last_data",  64'(rec0_q[5].data), 64'd101);
        end
        chk("skip0_checksum", 64'(checksum0), 64'd219);

        // Stall four cycles on register beat 2
        tick();
        rec_q.delete();
        pulse_start();
        n = 0;
        stalled = 0;
        while (!done && n < 200) begin
            if (!stalled && out_valid && out_tag == 1'b0 && out_index == 16'd2) begin
                stalled   = 1;
                out_ready = 1'b0;
                repeat (4) tick();
                out_ready = 1'b1;
            end else begin
                tick();
            end
            n++;
        end
        chk("stall_done_reached", 64'(done), 64'd1);
        tick();
        check_literal_beats("stall");
        chk("stall_cycles", 64'(dump_cycles), 64'd17);

        // Reset in the memory phase, then a fresh dump
        done_count = 0;
        pulse_start();
        n = 0;
        while (!mem_rd_en && n < 50) begin
            tick();
            n++;
        end
        chk("mid_reset_reached_mem", 64'(mem_rd_en), 64'd1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset_async");
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("mid_reset_no_done", 64'(done_count), 64'd0);
        rec_q.delete();
        pulse_start();
        wait_done(100, "after_reset");
        tick();
        check_literal_beats("after_reset");

        // Start held through the whole dump: exactly one dump
        done_count = 0;
        rec_q.delete();
        start = 1'b1;
        tick();
        wait_done(100, "held");
        start = 1'b0;
        repeat (3) tick();
        chk("held_done_pulses", 64'(done_count), 64'd1);
        check_literal_beats("held");
        rec_q.delete();
        pulse_start();
        wait_done(100, "second");
        tick();
        check_literal_beats("second");

        // Randomized contents, backpressure and stray starts
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NR; i++) regs[i] = $urandom;
            for (int j = 0; j < MW; j++) mem[j] = $urandom;
            pulse_start();
            n = 0;
            while (!done && n < 400) begin
                out_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 7) == 0);
                tick();
                n++;
            end
            chk("rand_done_reached", 64'(done), 64'd1);
            start     = 1'b0;
            out_ready = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
